// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock FIFO with occupancy count, almost flags,
// sticky error flags, synchronous flush and standard/FWFT read modes.
module sync_fifo_pro #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_ok, rd_ok;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign almost_full  = count >= AF_LVL;
  assign almost_empty = count <= AE_LVL;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is legal when paired with a read.
  assign rd_ok = rd_en && !empty && !flush;
  assign wr_ok = wr_en && (!full || rd_en) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem[rd_ptr_q[AW-1:0]];
      end
      if (wr_en && !wr_ok) ovf_d = 1'b1;
      if (rd_en && !rd_ok) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end else begin : g_std
    assign dout = dout_q;
  end

endmodule
